// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - PIN synchroniser, parity and change IRQ; debounce FSM when GPIO_IN_DEBOUNCE_EN is defined
module gpio_in_cond #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [15:0] PIN,
   input  logic        PARITYSEL,
   input  logic        IRQ_ACK,
   output logic [16:0] GPIOIN,
   output logic        STABLE,
   output logic        CHANGE_IRQ
);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
      $error("gpio_in_cond: DEBOUNCE_CYCLES out of range 2..65535");
   end

   logic [15:0] s1_q;
   logic [15:0] s2_q;
   logic [15:0] data_q;
   logic        irq_q;
   logic        irq_d;
   logic        commit_chg;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= PIN;
         s2_q <= s1_q;
      end
   end

`ifdef GPIO_IN_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, SETTLE} state_t;

   state_t        state_q;
   logic [15:0]   cand_q;
   logic [CW-1:0] cnt_q;
   logic          stable_q;

   // Any disagreement between s2 and the candidate restarts the count.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         stable_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (s2_q != data_q) begin
                  cand_q   <= s2_q;
                  cnt_q    <= '0;
                  state_q  <= SETTLE;
                  stable_q <= 1'b0;
               end
            end
            SETTLE: begin
               if (s2_q != cand_q) begin
                  cand_q <= s2_q;
                  cnt_q  <= '0;
               end else if (cnt_q < CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end else begin
                  data_q   <= cand_q;
                  state_q  <= IDLE;
                  stable_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               stable_q <= 1'b1;
            end
         endcase
      end
   end

   assign commit_chg = (state_q == SETTLE) && (s2_q == cand_q) &&
                       (cnt_q == CNT_MAX) && (cand_q != data_q);
   assign STABLE     = stable_q;
`else
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         data_q <= '0;
      end else begin
         data_q <= s2_q;
      end
   end

   assign commit_chg = (s2_q != data_q);
   assign STABLE     = 1'b1;
`endif

   // A new change outranks an acknowledge on the same edge.
   always_comb begin
      irq_d = irq_q;
      if (commit_chg) begin
         irq_d = 1'b1;
      end else if (IRQ_ACK) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign GPIOIN     = {~^{data_q, PARITYSEL}, data_q};
   assign CHANGE_IRQ = irq_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb/tb_gpio_in_cond.sv - scoreboard bench for gpio_in_cond, expectations tagged by clock edge
module tb_gpio_in_cond;

   localparam int N = 16;
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
   localparam int LAT = N + 3;
`else
   localparam bit DEB = 1'b0;
   localparam int LAT = 3;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [15:0] PIN;
   logic        PARITYSEL;
   logic        IRQ_ACK;
   logic [16:0] GPIOIN;
   logic        STABLE;
   logic        CHANGE_IRQ;

   int edge_cnt = 0;
   int errors   = 0;
   int checks   = 0;

   typedef struct {
      int          edge_n;
      logic [15:0] data;
      logic        ps;
      logic        stable;
      logic        irq;
      string       name;
   } exp_t;

   exp_t sb[$];

   gpio_in_cond #(.DEBOUNCE_CYCLES(N)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .PIN       (PIN),
      .PARITYSEL (PARITYSEL),
      .IRQ_ACK   (IRQ_ACK),
      .GPIOIN    (GPIOIN),
      .STABLE    (STABLE),
      .CHANGE_IRQ(CHANGE_IRQ)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) edge_cnt <= edge_cnt + 1;

   always @(negedge HCLK) begin : monitor
      exp_t        e;
      logic [16:0] want;
      while (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
         e    = sb.pop_front();
         want = {~^{e.data, e.ps}, e.data};
         checks++;
         if (e.edge_n != edge_cnt || GPIOIN !== want || STABLE !== e.stable || CHANGE_IRQ !== e.irq) begin
            errors++;
            $display("FAIL %s @edge %0d (due %0d): GPIOIN=%05h STABLE=%b CHANGE_IRQ=%b, required GPIOIN=%05h STABLE=%b CHANGE_IRQ=%b",
                     e.name, edge_cnt, e.edge_n, GPIOIN, STABLE, CHANGE_IRQ, want, e.stable, e.irq);
         end
         checks++;
         if ((~^{GPIOIN, PARITYSEL, 1'b0}) !== 1'b0) begin
            errors++;
            $display("FAIL %s_perr @edge %0d: downstream parity error=%b, required 0",
                     e.name, edge_cnt, ~^{GPIOIN, PARITYSEL, 1'b0});
         end
      end
   end

   task automatic tick();
      @(negedge HCLK);
      #1;
   endtask

   task automatic wait_edge(input int e);
      while (edge_cnt < e) tick();
   endtask

   task automatic expect_at(input int e, input logic [15:0] d, input logic ps,
                            input logic st, input logic irq, input string nm);
      exp_t x;
      int   pos;
      x.edge_n = e;
      x.data   = d;
      x.ps     = ps;
      x.stable = st;
      x.irq    = irq;
      x.name   = nm;
      pos = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].edge_n > e) begin
            pos = i;
            break;
         end
      end
      sb.insert(pos, x);
   endtask

   task automatic commit_to(input logic [15:0] v, input string nm);
      int e0;
      PIN = v;
      e0  = edge_cnt;
      expect_at(e0 + LAT, v, 1'b0, 1'b1, 1'b1, nm);
      wait_edge(e0 + LAT + 1);
      IRQ_ACK = 1'b1;
      expect_at(edge_cnt + 1, v, 1'b0, 1'b1, 1'b0, {nm, "_ack"});
      tick();
      IRQ_ACK = 1'b0;
   endtask

   initial begin : stim
      int e0;
      int e1;
      int t0;
      int r;

      HRESETn   = 1'b0;
      PIN       = 16'h0000;
      PARITYSEL = 1'b0;
      IRQ_ACK   = 1'b0;

      // reset values under both parity senses
      expect_at(2, 16'h0000, 1'b0, 1'b1, 1'b0, "rst_ps0");
      wait_edge(3);
      PARITYSEL = 1'b1;
      expect_at(4, 16'h0000, 1'b1, 1'b1, 1'b0, "rst_ps1");
      wait_edge(5);
      PARITYSEL = 1'b0;
      HRESETn   = 1'b1;
      wait_edge(8);

      // clean change 0000 -> 00A5
      PIN = 16'h00A5;
      e0  = edge_cnt;
      expect_at(e0 + 4, DEB ? 16'h0000 : 16'h00A5, 1'b0, !DEB, !DEB, "clean_mid");
      expect_at(e0 + LAT - 1, 16'h0000, 1'b0, !DEB, 1'b0, "clean_not_before");
      expect_at(e0 + LAT, 16'h00A5, 1'b0, 1'b1, 1'b1, "clean_commit");
      expect_at(e0 + LAT + 2, 16'h00A5, 1'b0, 1'b1, 1'b1, "irq_sticky");
      wait_edge(e0 + LAT + 2);
      IRQ_ACK = 1'b1;
      expect_at(edge_cnt + 1, 16'h00A5, 1'b0, 1'b1, 1'b0, "ack_clear");
      tick();
      IRQ_ACK = 1'b0;

      // parity: 0x0003 under both senses
      PIN = 16'h0003;
      e0  = edge_cnt;
      expect_at(e0 + LAT, 16'h0003, 1'b0, 1'b1, 1'b1, "par_ps0");
      wait_edge(e0 + LAT + 1);
      PARITYSEL = 1'b1;
      IRQ_ACK   = 1'b1;
      expect_at(edge_cnt + 1, 16'h0003, 1'b1, 1'b1, 1'b0, "par_ps1");
      tick();
      IRQ_ACK   = 1'b0;
      PARITYSEL = 1'b0;

      commit_to(16'h0000, "to_zero_a");

      // bounce: toggle every 5 cycles for 40 cycles, then hold 0001
      t0 = edge_cnt;
      for (int k = 0; k < 8; k++) begin
         expect_at(t0 + 5 * k + 4, DEB ? 16'h0000 : ((k % 2 == 0) ? 16'h0001 : 16'h0000),
                   1'b0, !DEB, !DEB, $sformatf("bounce_hold%0d", k));
      end
      expect_at(t0 + 40 + LAT - 1, 16'h0000, 1'b0, !DEB, !DEB, "bounce_not_before");
      expect_at(t0 + 40 + LAT, 16'h0001, 1'b0, 1'b1, 1'b1, "bounce_commit");
      for (int k = 0; k < 8; k++) begin
         wait_edge(t0 + 5 * k);
         PIN = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      end
      wait_edge(t0 + 40);
      PIN = 16'h0001;
      wait_edge(t0 + 40 + LAT + 1);
      IRQ_ACK = 1'b1;
      tick();
      IRQ_ACK = 1'b0;

      commit_to(16'h0000, "to_zero_b");

      // glitch back: FFFF for 4 cycles then 0000
      PIN = 16'hFFFF;
      e0  = edge_cnt;
      e1  = e0 + 4;
      expect_at(e0 + 4, DEB ? 16'h0000 : 16'hFFFF, 1'b0, !DEB, !DEB, "glitch_mid");
      expect_at(e1 + LAT - 1, DEB ? 16'h0000 : 16'hFFFF, 1'b0, !DEB, !DEB, "glitch_settling");
      expect_at(e1 + LAT, 16'h0000, 1'b0, 1'b1, !DEB, "glitch_back");
      wait_edge(e1);
      PIN = 16'h0000;
      wait_edge(e1 + LAT + 1);
      IRQ_ACK = 1'b1;
      tick();
      IRQ_ACK = 1'b0;

      // IRQ race: ack on the commit edge, then on the next edge
      PIN = 16'h0005;
      e0  = edge_cnt;
      expect_at(e0 + LAT, 16'h0005, 1'b0, 1'b1, 1'b1, "race_set_wins");
      expect_at(e0 + LAT + 1, 16'h0005, 1'b0, 1'b1, 1'b0, "race_ack_next");
      wait_edge(e0 + LAT - 1);
      IRQ_ACK = 1'b1;
      wait_edge(e0 + LAT + 1);
      IRQ_ACK = 1'b0;

      // reset in the middle of settling (cnt = 8 in the debounced build)
      PIN = 16'h00A5;
      e0  = edge_cnt;
      expect_at(e0 + 11, DEB ? 16'h0005 : 16'h00A5, 1'b0, !DEB, !DEB, "pre_reset");
      expect_at(e0 + 12, 16'h0000, 1'b0, 1'b1, 1'b0, "reset_mid");
      wait_edge(e0 + 11);
      HRESETn = 1'b0;
      wait_edge(e0 + 13);
      HRESETn = 1'b1;
      r = edge_cnt;
      expect_at(r + LAT - 1, 16'h0000, 1'b0, !DEB, 1'b0, "rst_no_early");
      expect_at(r + LAT, 16'h00A5, 1'b0, 1'b1, 1'b1, "recommit");
      wait_edge(r + LAT + 3);

      while (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: never checked (due edge %0d, run ended at edge %0d)", x.name, x.edge_n, edge_cnt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
